// File: rtl/obstacle_scheduler_if.sv
// rtl/obstacle_scheduler_if.sv - control strobes and game-state outputs of the obstacle scheduler
interface obstacle_scheduler_if;
  logic       tick;
  logic       sec_tick;
  logic       start;
  logic       left;
  logic       right;
  logic [2:0] player_col;
  logic [2:0] obj_vld;
  logic [8:0] obj_col;
  logic [8:0] obj_row;
  logic [1:0] lives;
  logic [6:0] elapsed;
  logic [2:0] state;
  logic       hit;

  modport master (
    output tick, sec_tick, start, left, right,
    input  player_col, obj_vld, obj_col, obj_row, lives, elapsed, state, hit
  );

  modport slave (
    input  tick, sec_tick, start, left, right,
    output player_col, obj_vld, obj_col, obj_row, lives, elapsed, state, hit
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - falling-obstacle game scheduler: player, three object slots, lives and survival timer
module obstacle_scheduler #(
  parameter int LIVES     = 3,
  parameter int HIT_TICKS = 4,
  parameter int WIN_SECS  = 20
) (
  input  logic                 CLK,
  input  logic                 clear,
  obstacle_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_OVER = 3'd3,
    S_WIN  = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_TICKS - 1);
  localparam logic [6:0] WIN_LIMIT  = 7'(WIN_SECS);
  localparam logic [6:0] SEC_MAX    = 7'd99;
  localparam logic [2:0] COL_START  = 3'd3;

  state_t     state;
  logic [7:0] lfsr;
  logic [2:0] player_col;
  logic [2:0] obj_vld;
  logic [8:0] obj_col;
  logic [8:0] obj_row;
  logic [1:0] lives;
  logic [6:0] elapsed;
  logic       hit;
  logic [7:0] hit_cnt;

  logic [2:0] col_mv;
  logic [2:0] vld_adv;
  logic [8:0] row_adv;
  logic [8:0] col_adv;
  logic       blocked;
  logic       launched;
  logic       collide;
  logic [6:0] elapsed_nxt;
  logic [1:0] lives_dec;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    col_mv = player_col;
    if (bus.right && !bus.left && player_col != 3'd7) begin
      col_mv = player_col + 3'd1;
    end else if (bus.left && !bus.right && player_col != 3'd0) begin
      col_mv = player_col - 3'd1;
    end
  end

  // Advance first, then decide the launch and the collision on the advanced picture.
  always_comb begin
    vld_adv  = obj_vld;
    row_adv  = obj_row;
    col_adv  = obj_col;
    blocked  = 1'b0;
    launched = 1'b0;
    collide  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (obj_vld[k]) begin
        if (obj_row[3*k +: 3] == 3'd7) begin
          vld_adv[k] = 1'b0;
        end else begin
          row_adv[3*k +: 3] = obj_row[3*k +: 3] + 3'd1;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (vld_adv[k] && row_adv[3*k +: 3] <= 3'd1) begin
        blocked = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!launched && !blocked && !vld_adv[k]) begin
        vld_adv[k]        = 1'b1;
        row_adv[3*k +: 3] = 3'd0;
        col_adv[3*k +: 3] = lfsr[2:0];
        launched          = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (vld_adv[k] && row_adv[3*k +: 3] >= 3'd6 && col_adv[3*k +: 3] == col_mv) begin
        collide = 1'b1;
      end
    end
  end

  always_comb begin
    elapsed_nxt = elapsed;
    if (bus.sec_tick && elapsed < SEC_MAX) begin
      elapsed_nxt = elapsed + 7'd1;
    end
    lives_dec = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
  end

  always_ff @(posedge CLK or negedge clear) begin
    if (!clear) begin
      state      <= S_IDLE;
      lfsr       <= 8'hA5;
      player_col <= COL_START;
      obj_vld    <= 3'b000;
      obj_col    <= 9'd0;
      obj_row    <= 9'd0;
      lives      <= LIVES_INIT;
      elapsed    <= 7'd0;
      hit        <= 1'b0;
      hit_cnt    <= 8'd0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      hit  <= 1'b0;
      case (state)
        S_IDLE, S_OVER, S_WIN: begin
          obj_vld <= 3'b000;
          if (bus.start) begin
            lives      <= LIVES_INIT;
            player_col <= COL_START;
            elapsed    <= 7'd0;
            hit_cnt    <= 8'd0;
            state      <= S_PLAY;
          end
        end
        S_PLAY: begin
          elapsed <= elapsed_nxt;
          if (bus.tick) begin
            player_col <= col_mv;
            obj_vld    <= vld_adv;
            obj_row    <= row_adv;
            obj_col    <= col_adv;
          end
          // A collision outranks reaching the win time; WIN is then taken from HIT.
          if (bus.tick && collide) begin
            hit     <= 1'b1;
            lives   <= lives_dec;
            obj_vld <= 3'b000;
            hit_cnt <= 8'd0;
            state   <= (lives_dec != 2'd0) ? S_HIT : S_OVER;
          end else if (elapsed_nxt >= WIN_LIMIT) begin
            obj_vld <= 3'b000;
            state   <= S_WIN;
          end
        end
        S_HIT: begin
          elapsed <= elapsed_nxt;
          if (elapsed_nxt >= WIN_LIMIT) begin
            hit_cnt <= 8'd0;
            state   <= S_WIN;
          end else if (bus.tick) begin
            if (hit_cnt >= HIT_LAST) begin
              hit_cnt <= 8'd0;
              state   <= S_PLAY;
            end else begin
              hit_cnt <= hit_cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.player_col = player_col;
  assign bus.obj_vld    = obj_vld;
  assign bus.obj_col    = obj_col;
  assign bus.obj_row    = obj_row;
  assign bus.lives      = lives;
  assign bus.elapsed    = elapsed;
  assign bus.state      = state;
  assign bus.hit        = hit;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed bench for obstacle_scheduler
module tb_obstacle_scheduler;

  logic CLK = 1'b0;
  logic clear;
  always #5 CLK = ~CLK;

  obstacle_scheduler_if bus();

  obstacle_scheduler #(.LIVES(3), .HIT_TICKS(4), .WIN_SECS(20)) dut (
    .CLK   (CLK),
    .clear (clear),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference LFSR: taps 8,6,5,4, seed A5, free-running from reset.
  logic [7:0] m_lfsr;
  always @(posedge CLK or negedge clear) begin
    if (!clear) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  logic [2:0] launch_col;

  typedef struct {
    bit         restart;
    bit         l;
    bit         r;
    logic [2:0] exp_col;
  } mv_t;

  mv_t vec [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one clock of inputs and returns at the next negedge.
  task automatic step(input bit tk, input bit sec, input bit st, input bit l, input bit r);
    bus.tick     = tk;
    bus.sec_tick = sec;
    bus.start    = st;
    bus.left     = l;
    bus.right    = r;
    launch_col   = m_lfsr[2:0];
    @(negedge CLK);
    bus.tick     = 1'b0;
    bus.sec_tick = 1'b0;
    bus.start    = 1'b0;
    bus.left     = 1'b0;
    bus.right    = 1'b0;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    @(negedge CLK);
    clear = 1'b1;
  endtask

  task automatic start_game();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Launch slot0 from an empty field, steer onto its column, collide on the 7th tick (row 6).
  task automatic collide_once(input bit sec_last);
    logic [2:0] c;
    bit l, r;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    c = launch_col;
    for (int i = 0; i < 6; i++) begin
      l = (bus.player_col > c);
      r = (bus.player_col < c);
      step(1'b1, sec_last && (i == 5), 1'b0, l, r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{1'b1, 1'b0, 1'b1, 3'd4};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 3'd5};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 3'd6};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 3'd7};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 3'd7};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 3'd7};
    vec[6]  = '{1'b1, 1'b1, 1'b1, 3'd3};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 3'd2};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 3'd1};
    vec[9]  = '{1'b0, 1'b1, 1'b0, 3'd0};
    vec[10] = '{1'b0, 1'b1, 1'b0, 3'd0};
    vec[11] = '{1'b0, 1'b0, 1'b1, 3'd1};

    clear = 1'b0;
    bus.tick = 1'b0; bus.sec_tick = 1'b0; bus.start = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_state", bus.state, 0);
    chk("rst_col", bus.player_col, 3);
    chk("rst_lives", bus.lives, 3);
    chk("rst_elapsed", bus.elapsed, 0);
    chk("rst_vld", bus.obj_vld, 0);
    chk("rst_obj_col", bus.obj_col, 0);
    chk("rst_obj_row", bus.obj_row, 0);
    chk("rst_hit", bus.hit, 0);
    clear = 1'b1;

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("idle_ignore_state", bus.state, 0);
    chk("idle_ignore_elapsed", bus.elapsed, 0);

    // Launch pattern with no player movement.
    start_game();
    chk("start_state", bus.state, 1);
    chk("start_lives", bus.lives, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_vld", bus.obj_vld, 3'b001);
    chk("t1_row0", bus.obj_row[2:0], 0);
    chk("t1_col0", bus.obj_col[2:0], launch_col);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_vld", bus.obj_vld, 3'b001);
    chk("t2_row0", bus.obj_row[2:0], 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_vld", bus.obj_vld, 3'b011);
    chk("t3_row1", bus.obj_row[5:3], 0);
    chk("t3_col1", bus.obj_col[5:3], launch_col);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_vld", bus.obj_vld, 3'b011);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_vld", bus.obj_vld, 3'b111);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_row0", bus.obj_row[2:0], 5);
    chk("t6_row2", bus.obj_row[8:6], 1);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t10_col", bus.player_col, 3);

    // Player movement table.
    for (int i = 0; i < 12; i++) begin
      if (vec[i].restart) begin
        do_reset();
        start_game();
      end
      step(1'b1, 1'b0, 1'b0, vec[i].l, vec[i].r);
      chk($sformatf("move_%0d", i), bus.player_col, vec[i].exp_col);
    end

    // Collision, freeze for four ticks, then back to PLAY.
    do_reset();
    start_game();
    collide_once(1'b0);
    chk("hit1_pulse", bus.hit, 1);
    chk("hit1_lives", bus.lives, 2);
    chk("hit1_vld", bus.obj_vld, 0);
    chk("hit1_state", bus.state, 2);
    begin
      logic [2:0] frozen;
      frozen = bus.player_col;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hit1_pulse_end", bus.hit, 0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("hit1_still_hit", bus.state, 2);
      chk("hit1_frozen_col", bus.player_col, frozen);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hit1_back_play", bus.state, 1);
    end

    collide_once(1'b0);
    chk("hit2_lives", bus.lives, 1);
    chk("hit2_state", bus.state, 2);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hit2_back_play", bus.state, 1);
    collide_once(1'b0);
    chk("hit3_pulse", bus.hit, 1);
    chk("hit3_lives", bus.lives, 0);
    chk("hit3_state", bus.state, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("over_hold", bus.state, 3);
    chk("over_vld", bus.obj_vld, 0);
    chk("over_hit", bus.hit, 0);
    chk("over_lives", bus.lives, 0);
    start_game();
    chk("restart_state", bus.state, 1);
    chk("restart_lives", bus.lives, 3);
    chk("restart_elapsed", bus.elapsed, 0);

    // Survival timer, start ignored in PLAY, win at 20 s.
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("play_start_ign_el", bus.elapsed, 5);
    chk("play_start_ign_st", bus.state, 1);
    repeat (14) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sec19_elapsed", bus.elapsed, 19);
    chk("sec19_state", bus.state, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sec20_elapsed", bus.elapsed, 20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("win_state", bus.state, 4);
    chk("win_vld", bus.obj_vld, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("win_hold_elapsed", bus.elapsed, 20);

    // Collision on the same edge as the 20th second.
    do_reset();
    start_game();
    repeat (19) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    collide_once(1'b1);
    chk("coin_state_hit", bus.state, 2);
    chk("coin_hit", bus.hit, 1);
    chk("coin_elapsed", bus.elapsed, 20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("coin_state_win", bus.state, 4);
    chk("coin_win_hit", bus.hit, 0);

    // Asynchronous reset in the middle of a clock phase.
    do_reset();
    start_game();
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pre_async_col", bus.player_col, 6);
    #2 clear = 1'b0;
    #1;
    chk("async_state", bus.state, 0);
    chk("async_col", bus.player_col, 3);
    chk("async_vld", bus.obj_vld, 0);
    chk("async_row", bus.obj_row, 0);
    chk("async_elapsed", bus.elapsed, 0);
    chk("async_lives", bus.lives, 3);
    @(negedge CLK);
    clear = 1'b1;
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_async_idle", bus.state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Parameters
REQ-001 The block SHALL have parameter LIVES, default 3, meaning starting life count (1..3).
REQ-002 The block SHALL have parameter HIT_TICKS, default 4, meaning freeze length in move ticks after a non-fatal hit.
REQ-003 The block SHALL have parameter WIN_SECS, default 20, meaning survival time in seconds to win (1..99).

Interface
REQ-004 CLK  in  1  system clock, all logic on posedge.
REQ-005 clear  in  1  reset, asynchronous, active-low.
REQ-006 tick  in  1  one-cycle move strobe from the move divider.
REQ-007 sec_tick  in  1  one-cycle 1 Hz strobe.
REQ-008 start  in  1  level, begins a game from IDLE, OVER or WIN.
REQ-009 left, right  in  1 each  player move requests, sampled on tick.
REQ-010 player_col  out  3  player column 0..7.
REQ-011 obj_vld  out  3  per-slot object valid.
REQ-012 obj_col, obj_row  out  9 each  packed 3x3-bit column/row, slot k at [3k+2:3k].
REQ-013 lives  out  2  remaining lives.
REQ-014 elapsed  out  7  seconds survived, 0..99.
REQ-015 state  out  3  IDLE=0, PLAY=1, HIT=2, OVER=3, WIN=4.
REQ-016 hit  out  1  one-cycle pulse on collision.

Function
REQ-017 An 8-bit LFSR (taps 8,6,5,4, seed 8'hA5, never zero) SHALL advance every clock in all states.
REQ-018 IDLE/OVER/WIN: start=1 SHALL load lives=LIVES, player_col=3, elapsed=0, all obj_vld=0, and enter PLAY next cycle; other inputs ignored.
REQ-019 PLAY, on tick, player: right&~left and col<7 -> col+1; left&~right and col>0 -> col-1; both or neither -> hold; edges saturate.
REQ-020 PLAY, on tick, every valid object SHALL advance row+1; an object at row 7 SHALL become invalid instead.
REQ-021 PLAY, on tick, after advance, at most one launch: lowest-index invalid slot, only if no valid object is at row 0 or 1; launched object row=0, col=LFSR[2:0].
REQ-022 Collision SHALL be checked on the same tick on post-move, post-advance values: any valid object with row>=6 and col==player_col.
REQ-023 On collision: hit=1 for one cycle, lives-1, all obj_vld cleared; next state HIT if new lives>0, else OVER.
REQ-024 HIT SHALL count HIT_TICKS ticks with player and objects frozen, then return to PLAY; left/right ignored.
REQ-025 elapsed SHALL increment on sec_tick in PLAY and HIT only, saturating at 99.
REQ-026 When elapsed reaches WIN_SECS in PLAY or HIT, state SHALL go to WIN next cycle; a collision in the same cycle takes priority (HIT/OVER) and WIN is re-evaluated next cycle.
REQ-027 tick and sec_tick in the same cycle SHALL both be processed.
REQ-028 start during PLAY or HIT SHALL be ignored.
REQ-029 In OVER and WIN all outputs SHALL hold their last values except obj_vld=0 and hit=0.
REQ-030 Arithmetic on rows, columns and counters SHALL never wrap; bounds as above.

Reset
REQ-031 clear=0 SHALL immediately force state=IDLE, player_col=3, obj_vld=0, obj_col=0, obj_row=0, lives=LIVES, elapsed=0, hit=0, HIT counter=0, LFSR=8'hA5.
REQ-032 Reset asserted mid-game SHALL discard all game progress; after release the block waits in IDLE for start.

Verification
REQ-033 Reset, start, 10 ticks with no move -> player_col=3, slot0 launched at tick 1, slot1 launched once slot0 row>=2, no launch while any object at row 0/1.
REQ-034 right held for 6 ticks from col 3 -> col 4,5,6,7,7,7; left+right together -> col unchanged.
REQ-035 Force object into player column reaching row 6, LIVES=3 -> hit pulse 1 cycle, lives=2, obj_vld=0, state HIT for 4 ticks then PLAY.
REQ-036 Three collisions -> lives 2,1,0, final state OVER; start -> PLAY with lives=3, elapsed=0.
REQ-037 20 sec_ticks with no collision -> elapsed=20, state WIN; collision coinciding with 20th sec_tick -> HIT first, WIN next cycle.
REQ-038 clear pulsed low mid-PLAY between clock edges -> outputs at reset values without waiting for CLK.
